// File: rtl/hack_pkg.sv
// Shared Hack datapath definitions: word width, word type and the two
// constant words used by the gate-level chips.
package hack_pkg;

  localparam int HACK_WORD = 16;

  typedef logic [HACK_WORD-1:0] hack_word_t;

  localparam hack_word_t WORD_ZERO = 16'h0000;
  localparam hack_word_t WORD_ONES = 16'hFFFF;

endpackage : hack_pkg

// File: rtl/nand2.sv
// Two-input NAND: the single gate primitive every Hack chip is built from.
module nand2 (
  input  logic a,
  input  logic b,
  output logic y
);

  // Inversion lives only here; all other logic composes this cell.
  assign y = ~(a & b);

endmodule : nand2

// File: rtl/not_16.sv
// 16-bit Hack NOT chip. The combinational result comes from a row of NAND
// cells with both inputs tied together; a registered copy and a one-cycle
// change flag are provided for pipelined consumers.
module not_16
  import hack_pkg::*;
#(
  parameter int WIDTH = HACK_WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             chg_q
);

  logic [WIDTH-1:0] out_d;
  logic             chg_d;

  // NAND(x, x) == NOT x; X/Z on an input bit propagates naturally as X.
  for (genvar i = 0; i < WIDTH; i++) begin : g_inv
    nand2 u_nand2 (
      .a (in[i]),
      .b (in[i]),
      .y (out[i])
    );
  end

  // Next registered value and change flag, compared against the current copy.
  always_comb begin
    out_d = out;
    chg_d = (out != out_q);
  end

  // Registered copy and change flag; reset clears both without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      chg_q <= 1'b0;
    end else begin
      out_q <= out_d;
      chg_q <= chg_d;
    end
  end

endmodule : not_16

// File: tb/tb_not_16.sv
// Directed and random checks for not_16 against a word-level model.
module tb_not_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_s;
  logic [15:0] out_s;
  logic [15:0] out_q_s;
  logic        chg_q_s;

  int errors = 0;
  int checks = 0;

  // Model state for the registered outputs.
  logic [15:0] m_q;
  logic        m_chg;

  not_16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_s),
    .out   (out_s),
    .out_q (out_q_s),
    .chg_q (chg_q_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inverse of a 16-bit word computed arithmetically.
  function automatic logic [15:0] inv(input logic [15:0] v);
    int r;
    r = 65535 - int'(v);
    return r[15:0];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge: advance the model, then sample the registered outputs.
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      m_q   = 16'h0000;
      m_chg = 1'b0;
    end else begin
      m_chg = (inv(in_s) != m_q);
      m_q   = inv(in_s);
    end
    #1;
    check({tag, "_out_q"}, out_q_s, m_q);
    check({tag, "_chg_q"}, {15'd0, chg_q_s}, {15'd0, m_chg});
  endtask

  initial begin
    logic [15:0] v;
    rst_n = 1'b0;
    in_s  = 16'h0000;
    m_q   = 16'h0000;
    m_chg = 1'b0;

    // Combinational path before any clock edge.
    #1;
    check("zero_in", out_s, 16'hFFFF);
    check("reset_out_q", out_q_s, 16'h0000);
    check("reset_chg_q", {15'd0, chg_q_s}, 16'h0000);
    in_s = 16'hFFFF; #1; check("ones_in", out_s, 16'h0000);
    in_s = 16'hAAAA; #1; check("aaaa_in", out_s, 16'h5555);
    in_s = 16'h1234; #1; check("1234_in", out_s, 16'hEDCB);

    // Held in reset with clocks running.
    in_s = 16'hAAAA;
    for (int k = 0; k < 3; k++) begin
      step("in_reset");
      check("in_reset_out", out_s, 16'h5555);
    end

    // Release between edges, then first and second edge.
    @(negedge clk);
    rst_n = 1'b1;
    step("first_edge");
    check("first_edge_q_val", out_q_s, 16'h5555);
    check("first_edge_chg_val", {15'd0, chg_q_s}, 16'h0001);
    step("second_edge");
    check("second_edge_chg_val", {15'd0, chg_q_s}, 16'h0000);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    m_q   = 16'h0000;
    m_chg = 1'b0;
    check("async_rst_out_q", out_q_s, 16'h0000);
    check("async_rst_chg_q", {15'd0, chg_q_s}, 16'h0000);
    check("async_rst_out", out_s, 16'h5555);
    @(negedge clk);
    rst_n = 1'b1;

    // Walking one: exactly one zero at the driven bit.
    for (int i = 0; i < 16; i++) begin
      v = 16'h0001 << i;
      in_s = v;
      #1;
      check($sformatf("walk1_bit%0d", i), out_s, inv(v));
      step($sformatf("walk1_reg%0d", i));
    end

    // Random vectors, checking both combinational and registered outputs.
    for (int n = 0; n < 1000; n++) begin
      in_s = 16'($urandom);
      #1;
      check("rand_out", out_s, inv(in_s));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule : tb_not_16
